// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: decodes RS/RW/E/DB strobes into a 2x16 DDRAM mirror
// plus AC/flags, answers BF/AC reads. Optional DDRAM data reads under LCD_DATA_READ_EN.
// Ports: clock, reset (async, low); bus RS/RW/E/DB_in -> DB_out/DB_oe;
// state busy/addr/display_on/cursor_on/blink_on/inc_mode/func_sets/overrun; mirror rd_idx->rd_char.
module lcd_bus_responder #(
  parameter int EXEC_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 1520
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RS,
  input  logic       RW,
  input  logic       E,
  input  logic [7:0] DB_in,
  output logic [7:0] DB_out,
  output logic       DB_oe,
  output logic       busy,
  output logic [6:0] addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic [1:0] func_sets,
  output logic       overrun,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char
);

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, HOME} state_t;

  localparam int MAXC = (EXEC_CYCLES > CLEAR_CYCLES) ?
                        EXEC_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] EXEC_LD = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LD  = CW'(CLEAR_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    clr_idx;
  logic [7:0]    ddram [32];
  logic          e_s1, e_s2, e_s3;
  logic          strobe, wr_stb;
  logic          in_win;
  logic [4:0]    widx;
  logic [7:0]    rd_data;

  // Columns 0x10-0x3F of either line have no backing cell;
  // stepping from there lands on the start of that line.
  function automatic logic [6:0] step(input logic [6:0] a,
                                      input logic inc);
    if (a[5:4] != 2'b00)
      return {a[6], 6'h00};
    if (inc)
      return (a[3:0] == 4'hF) ? {~a[6], 6'h00} : a + 7'd1;
    return (a[3:0] == 4'h0) ? {~a[6], 6'h0F} : a - 7'd1;
  endfunction

  assign strobe  = e_s3 & ~e_s2;
  assign wr_stb  = strobe & ~RW;
  assign in_win  = (addr[5:4] == 2'b00);
  assign widx    = {addr[6], addr[3:0]};
  assign rd_char = ddram[rd_idx];

`ifdef LCD_DATA_READ_EN
  logic rd_stb;
  assign rd_stb  = strobe & RW;
  assign rd_data = ddram[widx];
`else
  assign rd_data = 8'h00;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_s1       <= 1'b0;
      e_s2       <= 1'b0;
      e_s3       <= 1'b0;
      DB_out     <= 8'h00;
      DB_oe      <= 1'b0;
      busy       <= 1'b0;
      addr       <= 7'h00;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      inc_mode   <= 1'b1;
      func_sets  <= 2'd0;
      overrun    <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      clr_idx    <= 6'd0;
      for (int i = 0; i < 32; i++)
        ddram[i] <= 8'h20;
    end else begin
      e_s1  <= E;
      e_s2  <= e_s1;
      e_s3  <= e_s2;
      DB_oe <= e_s2 & RW;
      if (e_s2 & RW)
        DB_out <= RS ? rd_data : {busy, addr};
      if (wr_stb & busy)
        overrun <= 1'b1;
`ifdef LCD_DATA_READ_EN
      if (rd_stb & RS)
        addr <= step(addr, inc_mode);
`endif
      unique case (state)
        IDLE: begin
          if (wr_stb) begin
            busy  <= 1'b1;
            state <= EXEC;
            cnt   <= EXEC_LD;
            if (RS) begin
              if (in_win)
                ddram[widx] <= DB_in;
              addr <= step(addr, inc_mode);
            end else begin
              unique case (1'b1)
                DB_in[7]:
                  addr <= DB_in[6:0];
                DB_in[7:5] == 3'b001:
                  if (func_sets != 2'd3)
                    func_sets <= func_sets + 2'd1;
                DB_in[7:3] == 5'b00001: begin
                  display_on <= DB_in[2];
                  cursor_on  <= DB_in[1];
                  blink_on   <= DB_in[0];
                end
                DB_in[7:2] == 6'b000001:
                  inc_mode <= DB_in[1];
                DB_in[7:1] == 7'b0000001: begin
                  addr  <= 7'h00;
                  state <= HOME;
                  cnt   <= CLR_LD;
                end
                DB_in == 8'h01: begin
                  addr     <= 7'h00;
                  inc_mode <= 1'b1;
                  state    <= CLEAR;
                  cnt      <= CLR_LD;
                  clr_idx  <= 6'd0;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
          // Clear fill: one cell per clock inside the busy window.
          if (state == CLEAR && !clr_idx[5]) begin
            ddram[clr_idx[4:0]] <= 8'h20;
            clr_idx <= clr_idx + 6'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Testbench for lcd_bus_responder: directed steps plus a random
// instruction/data stream checked against a behavioural LCD model.
module tb_lcd_bus_responder;

  localparam int EXEC = 24;
  localparam int CLR  = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       RS = 1'b0, RW = 1'b0, E = 1'b0;
  logic [7:0] DB_in = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] DB_out, rd_char;
  logic       DB_oe, busy, overrun;
  logic [6:0] addr;
  logic       display_on, cursor_on, blink_on, inc_mode;
  logic [1:0] func_sets;

  lcd_bus_responder #(.EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLR)) dut (
    .clock(clock), .reset(reset), .RS(RS), .RW(RW), .E(E),
    .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe), .busy(busy),
    .addr(addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .inc_mode(inc_mode), .func_sets(func_sets),
    .overrun(overrun), .rd_idx(rd_idx), .rd_char(rd_char)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int m_ram [32];
  int m_addr, m_fs;
  bit m_inc, m_disp, m_cur, m_blk, m_ovr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
    m_addr = 0; m_fs = 0; m_inc = 1;
    m_disp = 0; m_cur = 0; m_blk = 0; m_ovr = 0;
  endtask

  function automatic int m_next(input int a);
    int line = a / 64;
    int col  = a % 64;
    if (col > 15) return line * 64;
    if (m_inc) return (col == 15) ? (1 - line) * 64 : a + 1;
    return (col == 0) ? (1 - line) * 64 + 15 : a - 1;
  endfunction

  task automatic m_apply(input bit rs, input int d, output int dur);
    dur = EXEC;
    if (rs) begin
      if (m_addr % 64 < 16)
        m_ram[(m_addr / 64) * 16 + m_addr % 64] = d;
      m_addr = m_next(m_addr);
    end
    else if (d >= 128) m_addr = d - 128;
    else if (d >= 64) ;
    else if (d >= 32) begin if (m_fs < 3) m_fs++; end
    else if (d >= 16) ;
    else if (d >= 8) begin
      m_disp = d[2]; m_cur = d[1]; m_blk = d[0];
    end
    else if (d >= 4) m_inc = d[1];
    else if (d >= 2) begin m_addr = 0; dur = CLR; end
    else begin
      for (int i = 0; i < 32; i++) m_ram[i] = 8'h20;
      m_addr = 0; m_inc = 1; dur = CLR;
    end
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] d);
    RS = rs; RW = 1'b0; DB_in = d;
    tick(1);
    E = 1'b1;
    tick(3);
    E = 1'b0;
    tick(4);
  endtask

  task automatic bus_read(input bit rs, output logic [7:0] d,
                          output logic oe_hi, output logic oe_lo);
    RS = rs; RW = 1'b1;
    tick(1);
    E = 1'b1;
    tick(4);
    d = DB_out; oe_hi = DB_oe;
    E = 1'b0;
    tick(4);
    oe_lo = DB_oe;
    RW = 1'b0; RS = 1'b0;
  endtask

  task automatic do_op(input bit rs, input int d);
    int dur;
    bus_write(rs, d[7:0]);
    m_apply(rs, d, dur);
    tick(dur + 2);
  endtask

  task automatic measure(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick(1);
      n++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".addr"}, addr, m_addr);
    check({tag, ".inc"}, inc_mode, m_inc);
    check({tag, ".disp"}, {display_on, cursor_on, blink_on},
          {m_disp, m_cur, m_blk});
    check({tag, ".fs"}, func_sets, m_fs);
    check({tag, ".ovr"}, overrun, m_ovr);
    check({tag, ".busy"}, busy, 0);
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_idx = i[4:0];
      #1;
      check($sformatf("%s.ram%0d", tag, i), rd_char, m_ram[i]);
    end
  endtask

  initial begin
    int n, dur, r, d;
    logic [7:0] rdv;
    logic oe_hi, oe_lo;

    m_reset();
    tick(3);
    check("rst.dbout", DB_out, 0);
    check("rst.dboe", DB_oe, 0);
    check_state("rst");
    check_ram("rst");
    reset = 1'b1;
    tick(2);

    do_op(0, 8'h38); do_op(0, 8'h38); do_op(0, 8'h38);
    bus_write(0, 8'h0C);
    m_apply(0, 8'h0C, dur);
    measure(n);
    check("exec.len", n, EXEC - 1);
    tick(2);
    do_op(0, 8'h06);
    bus_write(0, 8'h01);
    m_apply(0, 8'h01, dur);
    measure(n);
    check("clear.len", n, CLR - 1);
    tick(2);
    check("init.fs", func_sets, 3);
    check("init.disp", {display_on, cursor_on}, 2'b10);
    check("init.addr", addr, 0);
    do_op(0, 8'h38);
    check_state("init");

    do_op(0, 8'h8F); do_op(1, 8'h41); do_op(1, 8'h42);
    rd_idx = 5'd15; #1; check("wrap.idx15", rd_char, 8'h41);
    rd_idx = 5'd16; #1; check("wrap.idx16", rd_char, 8'h42);
    check("wrap.addr", addr, 7'h41);
    check_state("wrap");

    do_op(0, 8'h04); do_op(0, 8'hC0); do_op(1, 8'h5A);
    rd_idx = 5'd16; #1; check("dec.idx16", rd_char, 8'h5A);
    check("dec.addr", addr, 7'h0F);
    do_op(0, 8'h06);

    bus_read(0, rdv, oe_hi, oe_lo);
    check("rd.idle", rdv, {1'b0, m_addr[6:0]});
    check("rd.oe_hi", oe_hi, 1);
    check("rd.oe_lo", oe_lo, 0);

    bus_write(0, 8'h85);
    m_apply(0, 8'h85, dur);
    bus_write(1, 8'h41);
    m_ovr = 1;
    bus_read(0, rdv, oe_hi, oe_lo);
    check("ovr.bf", rdv[7], 1);
    check("ovr.rd", rdv, {1'b1, 7'h05});
    check("ovr.flag", overrun, 1);
    tick(EXEC + 4);
    check_state("ovr");
    check_ram("ovr");

    do_op(0, 8'h80); do_op(1, 8'h4D); do_op(0, 8'h80);
    bus_read(1, rdv, oe_hi, oe_lo);
`ifdef LCD_DATA_READ_EN
    check("drd.data", rdv, m_ram[0]);
    m_addr = m_next(m_addr);
    check("drd.addr", addr, 7'h01);
`else
    check("drd.data", rdv, 8'h00);
    check("drd.addr", addr, 7'h00);
`endif
    check("drd.oe", {oe_hi, oe_lo}, 2'b10);

    do_op(0, 8'hA5); do_op(1, 8'h58);
    check("oow.addr", addr, 7'h00);
    do_op(0, 8'hE0); do_op(0, 8'h04); do_op(1, 8'h58);
    check("oow.addr2", addr, 7'h40);
    do_op(0, 8'h06);
    check_state("oow");
    check_ram("oow");

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        do_op(1, $urandom_range(8'h41, 8'h5A));
      end else begin
        case (r)
          4: d = 8'h80 | $urandom_range(0, 127);
          5: d = 8'h04 | $urandom_range(0, 3);
          6: d = 8'h08 | $urandom_range(0, 7);
          7: d = 8'h20 | $urandom_range(0, 31);
          8: d = ($urandom_range(0, 1) != 0) ?
                 (8'h10 | $urandom_range(0, 15)) :
                 (8'h40 | $urandom_range(0, 63));
          default: d = ($urandom_range(0, 3) == 0) ?
                       8'h01 : (8'h02 | $urandom_range(0, 1));
        endcase
        do_op(0, d);
      end
      check_state($sformatf("rnd%0d", k));
      n = $urandom_range(0, 31);
      rd_idx = n[4:0];
      #1;
      check($sformatf("rnd%0d.ram", k), rd_char, m_ram[n]);
    end
    check_ram("rnd");

    do_op(0, 8'hC4); do_op(1, 8'h51);
    bus_write(0, 8'h01);
    tick(10);
    reset = 1'b0;
    m_reset();
    tick(2);
    check("mrst.dbout", DB_out, 0);
    check("mrst.dboe", DB_oe, 0);
    check_state("mrst");
    check_ram("mrst");
    reset = 1'b1;
    tick(1);
    check("mrst.busy_rel", busy, 0);
    check_state("mrst_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
